// File: rtl/bcd_timer_ctrl.sv
// Four-digit BCD up/down timer with a prescaled count step and an IDLE/RUN/PAUSE/DONE
// control FSM; every output is driven straight from a register.
module bcd_timer_ctrl #(
  parameter logic [25:0] TICK_DIV = 26'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        mode,
  output logic [15:0] digits,
  output logic [1:0]  state,
  output logic        tick,
  output logic        done,
  output logic        load_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [25:0] cnt_r, cnt_nxt_s;
  logic [15:0] digits_r, digits_nxt_s;
  logic [15:0] preset_r, preset_nxt_s;
  logic        mode_r, mode_nxt_s;
  logic        tick_r, tick_nxt_s;
  logic        done_r;
  logic        load_err_r, load_err_nxt_s;
  logic [15:0] terminal_s;
  logic [15:0] step_s;

  function automatic logic bcd_valid(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) ok = ok & (v[4*i +: 4] <= 4'd9);
    return ok;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic [3:0]  nib;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nib          = r[4*i +: 4];
      r[4*i +: 4]  = carry ? ((nib == 4'd9) ? 4'd0 : nib + 4'd1) : nib;
      carry        = carry & (nib == 4'd9);
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic [3:0]  nib;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nib          = r[4*i +: 4];
      r[4*i +: 4]  = borrow ? ((nib == 4'd0) ? 4'd9 : nib - 4'd1) : nib;
      borrow       = borrow & (nib == 4'd0);
    end
    return r;
  endfunction

  assign terminal_s = mode_r ? 16'h0000 : preset_r;
  assign step_s     = mode_r ? bcd_dec(digits_r) : bcd_inc(digits_r);

  // Next-state: commands resolved by priority clear > load > stop > start, then the prescaler.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    digits_nxt_s   = digits_r;
    preset_nxt_s   = preset_r;
    mode_nxt_s     = mode_r;
    tick_nxt_s     = 1'b0;
    load_err_nxt_s = 1'b0;
    if (clear) begin
      state_nxt_s  = IDLE;
      cnt_nxt_s    = 26'd0;
      mode_nxt_s   = mode;
      digits_nxt_s = mode ? preset_r : 16'h0000;
    end else if (load) begin
      if ((state_r == IDLE) && bcd_valid(load_val)) begin
        preset_nxt_s = load_val;
        mode_nxt_s   = mode;
        digits_nxt_s = mode ? load_val : 16'h0000;
      end else begin
        load_err_nxt_s = 1'b1;
      end
    end else if (stop && (state_r == RUN)) begin
      state_nxt_s = PAUSE;
    end else if (start && ((state_r == IDLE) || (state_r == PAUSE))) begin
      if (digits_r == terminal_s) begin
        state_nxt_s = DONE;
        cnt_nxt_s   = 26'd0;
      end else begin
        state_nxt_s = RUN;
      end
    end else if (state_r == RUN) begin
      // The step lands on the same edge as the prescaler wrap.
      if (cnt_r == (TICK_DIV - 26'd1)) begin
        cnt_nxt_s    = 26'd0;
        tick_nxt_s   = 1'b1;
        digits_nxt_s = step_s;
        if (step_s == terminal_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end else begin
        cnt_nxt_s = cnt_r + 26'd1;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= 26'd0;
      digits_r   <= 16'h0000;
      preset_r   <= 16'h0000;
      mode_r     <= 1'b0;
      tick_r     <= 1'b0;
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      digits_r   <= digits_nxt_s;
      preset_r   <= preset_nxt_s;
      mode_r     <= mode_nxt_s;
      tick_r     <= tick_nxt_s;
      done_r     <= (state_nxt_s == DONE);
      load_err_r <= load_err_nxt_s;
    end
  end

  assign digits   = digits_r;
  assign state    = state_r;
  assign tick     = tick_r;
  assign done     = done_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Bench for bcd_timer_ctrl: directed scenarios plus random commands, checked against a
// decimal-integer reference model of the timer.
module tb_bcd_timer_ctrl;

  localparam int TD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, mode = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] digits;
  logic [1:0]  state;
  logic        tick, done, load_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: count held as a plain integer 0..9999.
  int m_state, m_val, m_preset, m_mode, m_cnt, m_tick, m_err;

  bcd_timer_ctrl #(.TICK_DIV(26'd2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_val(load_val), .mode(mode), .digits(digits), .state(state), .tick(tick),
    .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] tobcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int frombcd(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic bit all_digits(input logic [15:0] v);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_val = 0; m_preset = 0; m_mode = 0; m_cnt = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic model_step(input bit c, input bit l, input bit sp, input bit st,
                            input bit md, input logic [15:0] lv);
    int term;
    term   = m_mode ? 0 : m_preset;
    m_tick = 0;
    m_err  = 0;
    if (c) begin
      m_state = 0; m_cnt = 0; m_mode = md; m_val = md ? m_preset : 0;
    end else if (l) begin
      if (m_state == 0 && all_digits(lv)) begin
        m_preset = frombcd(lv); m_mode = md; m_val = md ? m_preset : 0;
      end else m_err = 1;
    end else if (sp && m_state == 1) begin
      m_state = 2;
    end else if (st && (m_state == 0 || m_state == 2)) begin
      if (m_val == term) begin m_state = 3; m_cnt = 0; end
      else m_state = 1;
    end else if (m_state == 1) begin
      if (m_cnt == TD - 1) begin
        m_cnt  = 0;
        m_tick = 1;
        m_val  = m_mode ? (m_val + 9999) % 10000 : (m_val + 1) % 10000;
        if (m_val == term) m_state = 3;
      end else m_cnt++;
    end
  endtask

  task automatic check_all();
    chk("digits", digits, tobcd(m_val));
    chk("state", {14'd0, state}, 16'(m_state));
    chk("tick", {15'd0, tick}, 16'(m_tick));
    chk("done", {15'd0, done}, 16'(m_state == 3));
    chk("load_err", {15'd0, load_err}, 16'(m_err));
    chk("nibbles_valid", {15'd0, all_digits(digits)}, 16'd1);
  endtask

  // One clock: drive inputs, advance the model, then compare just after the edge.
  task automatic cyc(input bit c, input bit l, input bit sp, input bit st,
                     input bit md, input logic [15:0] lv);
    clear = c; load = l; stop = sp; start = st; mode = md; load_val = lv;
    model_step(c, l, sp, st, md, lv);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    bit c, l, sp, st, md;
    logic [15:0] lv;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Up count to preset 0003.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    idle_n(6);
    chk("up3_digits", digits, 16'h0003);
    chk("up3_done", {15'd0, done}, 16'd1);

    // Down count from 0010; DONE load rejected, so clear first.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010);
    chk("done_load_err", {15'd0, load_err}, 16'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    idle_n(2);
    chk("down_first", digits, 16'h0009);
    idle_n(18);
    chk("down_zero", digits, 16'h0000);
    chk("down_done", {15'd0, state}, 16'd3);

    // Invalid nibble load is rejected.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00A1);
    chk("bad_load_err", {15'd0, load_err}, 16'd1);
    idle_n(1);
    chk("bad_load_pulse", {15'd0, load_err}, 16'd0);

    // Stop on a tick cycle suppresses the step; resume keeps cnt.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    idle_n(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("stop_state", {14'd0, state}, 16'd2);
    chk("stop_no_step", digits, 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    idle_n(1);
    chk("resume_step", digits, 16'h0001);

    // Carry chain 0099 -> 0100 toward preset 0199.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0199);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    idle_n(198);
    chk("carry_0099", digits, 16'h0099);
    idle_n(2);
    chk("carry_0100", digits, 16'h0100);

    // clear+start in PAUSE goes to IDLE; async reset mid-RUN.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("clear_start_idle", {14'd0, state}, 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    idle_n(5);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #3 rst = 1'b1;
    idle_n(2);

    // Random commands against the model.
    for (int k = 0; k < 4000; k++) begin
      c  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 6);
      sp = ($urandom_range(0, 99) < 6);
      st = ($urandom_range(0, 99) < 25);
      md = 1'($urandom_range(0, 1));
      lv = {8'h00, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 99) < 15) lv[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      cyc(c, l, sp, st, md, lv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
